div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle RV32M divider that consumes `div_valid` and `DIVop` from the control unit's multiplier-extension decoder.
- Returns `div_ready` together with a 32-bit result, which the main FSM writes back through ResultSrc.
- Implements DIV, DIVU, REM and REMU as a radix-2 restoring divider: one quotient bit per cycle, with fast paths for the spec-defined corner cases.
- Sits beside the ALU in the datapath; operands come from the register-read latches (A/B registers).

Parameters:
XLEN, 32, operand/result width; only 32 is verified.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
div_valid  input  1  request from control unit; held high until div_ready
DIVop  input  DIV_OP_WIDTH(2)  operation select: DIV, DIVU, REM, REMU
dividend  input  XLEN  rs1 value
divisor  input  XLEN  rs2 value
div_result  output  XLEN  quotient or remainder; valid while div_ready=1
div_ready  output  1  single-cycle completion pulse
div_busy  output  1  high from accept until the DONE state is left

Behaviour:
- One clock `clk`. Reset is synchronous, active-high: any edge with reset=1 forces state IDLE, div_ready=0, div_busy=0, div_result=0, and clears all internal registers. This applies mid-operation; no pulse is produced for an aborted operation.
- States:
  - IDLE: entered on reset.
  - CALC: 32 iterations.
  - DONE: asserts div_ready=1.
  - All outputs are registered.
- Accept rule: in IDLE with div_valid=1, sample DIVop, dividend and divisor at that edge (call it cycle 0). Input changes after that edge are ignored.
- Fast paths, taken at the accept edge (IDLE→DONE, so div_ready is high in cycle 1):
  - divisor==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
  - Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): DIV result 0x80000000; REM result 0.
- Normal path, IDLE→CALC:
  - Signed ops: latch abs(dividend) and abs(divisor), plus q_neg = sign(a)^sign(b) and r_neg = sign(a).
  - Unsigned ops: operands pass through unmodified and q_neg = r_neg = 0.
  - Iteration counter starts at 31 and decrements once per CALC cycle.
  - Each step: shift the remainder left by one and bring in the next dividend bit. Trial-subtract the divisor in XLEN+1 bits. If the result is non-negative, keep it and set the quotient bit.
- CALC→DONE when the counter reaches 0 (32 CALC cycles, cycles 1..32). At that edge div_result is loaded:
  - DIV/DIVU: quotient, negated if q_neg.
  - REM/REMU: remainder, negated if r_neg.
- Normal latency: div_ready is high in cycle 33.
- DONE lasts exactly one cycle, then returns to IDLE.
  - The requester deasserts div_valid in the cycle after div_ready.
  - If div_valid is still high in IDLE, a new operation is accepted. This is legal back-to-back operation.
- Abort: div_valid=0 during CALC returns the block to IDLE at the next edge, with no div_ready pulse and div_result unchanged.
- div_result holds its value after DONE until the next load.
- Results follow the RISC-V M spec: quotient truncates toward zero; the remainder takes the dividend's sign.

Decomposition:
- Shared package `div_pkg`, which also feeds the existing DIVop decoder:
  - DIV_OP_WIDTH
  - DIVop encodings: DIV=2'd0, DIVU=2'd1, REM=2'd2, REMU=2'd3
  - State enum: IDLE, CALC, DONE
  - XLEN default
- One natural combinational sub-module, `div_step`: takes the remainder, the dividend bit and the divisor; returns the next remainder and the quotient bit.

Test Plan:
- DIVU 100/7, div_valid held → div_ready pulses in cycle 33 only, result 14; repeat as REMU → result 2.
- DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD(-3); REM -7/2 → 0xFFFFFFFF(-1); REM 7/0xFFFFFFFE(-2) → 1.
- DIVU 5/0 → 0xFFFFFFFF with div_ready in cycle 1; REM 0x80000005/0 → 0x80000005 in cycle 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 in cycle 1; REM same operands → 0.
- reset=1 at cycle 10 of a DIVU → next cycle state IDLE, div_busy=0, div_result=0, no div_ready; the following DIVU 9/3 completes → 3 at cycle 33.
- Drop div_valid at cycle 5 → no div_ready ever; then back-to-back REMU 10/4 → 2 followed immediately by DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF, each with a 33-cycle latency.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the RV32M divider and the DIVop decoder.
//   DIV_OP_WIDTH - width of the DIVop operation select
//   div_op_e     - DIVop encodings (DIV, DIVU, REM, REMU)
//   div_state_e  - divider FSM states (IDLE, CALC, DONE)
//   XLEN_DEFAULT - default operand/result width
package div_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int DIV_OP_WIDTH = 2;

    typedef enum logic [DIV_OP_WIDTH-1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Signed variants are the ones with DIVop[0] clear.
    function automatic logic op_is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division step (combinational).
//   rem_in       - partial remainder, always < divisor
//   dividend_bit - next dividend bit shifted into the remainder
//   divisor      - divisor magnitude
//   rem_out      - next partial remainder
//   q_bit        - quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Because rem_in < divisor, shifted < 2*divisor, so the XLEN+1-bit
    // difference has its MSB set exactly when the subtraction went negative.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[XLEN];
        rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
//   clk        - system clock
//   reset      - synchronous, active-high reset
//   div_valid  - request, held high until div_ready
//   DIVop      - operation select (div_op_e)
//   dividend   - rs1 value
//   divisor    - rs2 value
//   div_result - quotient or remainder, valid while div_ready=1, held after
//   div_ready  - single-cycle completion pulse
//   div_busy   - high from accept until DONE is left
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    div_valid,
    input  logic [DIV_OP_WIDTH-1:0] DIVop,
    input  logic [XLEN-1:0]         dividend,
    input  logic [XLEN-1:0]         divisor,
    output logic [XLEN-1:0]         div_result,
    output logic                    div_ready,
    output logic                    div_busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  rem_r, quo_r, divisor_r;
    logic             q_neg, r_neg, op_rem_r;

    div_op_e          op_in;
    logic             in_signed, in_rem;
    logic             accept, fast, step_en, finish;
    logic [XLEN-1:0]  fast_result;
    logic [XLEN-1:0]  rem_next, quo_next;
    logic             q_bit;

    assign op_in     = div_op_e'(DIVop);
    assign in_signed = op_is_signed(op_in);
    assign in_rem    = op_is_rem(op_in);

    // quo_r starts as the dividend magnitude and is shifted left each step,
    // so its MSB feeds the remainder and quotient bits fill in from the LSB.
    div_step #(.XLEN(XLEN)) u_step (
        .rem_in       (rem_r),
        .dividend_bit (quo_r[XLEN-1]),
        .divisor      (divisor_r),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    assign quo_next = {quo_r[XLEN-2:0], q_bit};

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        fast        = 1'b0;
        fast_result = '0;
        step_en     = 1'b0;
        finish      = 1'b0;
        unique case (state)
            IDLE: begin
                if (div_valid) begin
                    accept = 1'b1;
                    if (divisor == '0) begin
                        fast        = 1'b1;
                        fast_result = in_rem ? dividend : '1;
                        state_next  = DONE;
                    end else if (in_signed && dividend == MIN_NEG && divisor == '1) begin
                        fast        = 1'b1;
                        fast_result = in_rem ? '0 : MIN_NEG;
                        state_next  = DONE;
                    end else begin
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                // Dropping the request mid-operation abandons it silently.
                if (!div_valid) begin
                    state_next = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt == '0) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the working registers are cleared too, not just the FSM,
            // so an aborted operation leaves nothing behind.
            cnt        <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            divisor_r  <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            op_rem_r   <= 1'b0;
            div_result <= '0;
            div_ready  <= 1'b0;
            div_busy   <= 1'b0;
        end else begin
            div_ready <= (state_next == DONE);
            div_busy  <= (state_next != IDLE);
            if (accept) begin
                op_rem_r  <= in_rem;
                q_neg     <= in_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                r_neg     <= in_signed & dividend[XLEN-1];
                // Negating MIN_NEG yields MIN_NEG, which is the right magnitude unsigned.
                quo_r     <= (in_signed && dividend[XLEN-1]) ? -dividend : dividend;
                divisor_r <= (in_signed && divisor[XLEN-1])  ? -divisor  : divisor;
                rem_r     <= '0;
                cnt       <= CNT_W'(XLEN - 1);
                if (fast) div_result <= fast_result;
            end
            if (step_en) begin
                rem_r <= rem_next;
                quo_r <= quo_next;
                cnt   <= cnt - CNT_W'(1);
                if (finish) begin
                    if (op_rem_r) div_result <= r_neg ? -rem_next : rem_next;
                    else          div_result <= q_neg ? -quo_next : quo_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_valid;
    div_op_e     div_op;
    logic [31:0] dividend, divisor;
    logic [31:0] div_result;
    logic        div_ready, div_busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_exp = '0;

    div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .DIVop      (div_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_result (div_result),
        .div_ready  (div_ready),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return (op == DIV || op == DIVU) ? 32'hFFFF_FFFF : a;
        case (op)
            DIV:     return ovf ? a : 32'(sa / sb);
            REM:     return ovf ? 32'h0 : 32'(sa % sb);
            DIVU:    return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at a negedge; the following posedge is the accept edge (cycle 0).
    // Returns at the negedge of the cycle in which div_ready was seen.
    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic busy1);
        div_op    = op;
        dividend  = a;
        divisor   = b;
        div_valid = 1'b1;
        lat       = -1;
        res       = 'x;
        busy1     = 1'bx;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = div_busy;
            if (div_ready) begin
                lat = c;
                res = div_result;
                break;
            end
        end
    endtask

    task automatic compare_op(input string name, input div_op_e op, input logic [31:0] a,
                              input logic [31:0] b, input int lat, input logic [31:0] res,
                              input logic busy1);
        logic [31:0] exp;
        int          exp_lat;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        last_exp = exp;
        vectors++;
        if (res !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h expected %h", name, res, exp);
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_cycle1: got %b expected 1", name, busy1);
        end
    endtask

    // Full transaction: issue, compare, drop div_valid, confirm single-cycle pulse.
    task automatic do_op(input string name, input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [31:0] res;
        logic        busy1;
        issue(op, a, b, lat, res, busy1);
        compare_op(name, op, a, b, lat, res, busy1);
        div_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: ready=%b busy=%b expected 0/0", name, div_ready, div_busy);
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        div_valid = 1'b0;
        div_op    = DIV;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (div_ready !== 1'b0 || div_busy !== 1'b0 || div_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b busy=%b result=%h expected 0/0/0", div_ready, div_busy, div_result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        do_op("divu_100_7", DIVU, 32'd100, 32'd7);
        do_op("remu_100_7", REMU, 32'd100, 32'd7);
    endtask

    task automatic test_signed;
        do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2);
        do_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_by_zero;
        do_op("divu_5_0", DIVU, 32'd5, 32'd0);
        do_op("rem_x_0", REM, 32'h8000_0005, 32'd0);
    endtask

    task automatic test_overflow;
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_reset_mid_op;
        bit seen = 0;
        div_op    = DIVU;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        div_valid = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        vectors++;
        if (div_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid busy_before: got %b expected 1", div_busy);
        end
        reset     = 1'b1;
        div_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (div_busy !== 1'b0 || div_ready !== 1'b0 || div_result !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid state: busy=%b ready=%b result=%h expected 0/0/0", div_busy, div_ready, div_result);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_ready) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL rst_mid stray_ready: got 1 expected 0");
        end
        do_op("rst_then_divu_9_3", DIVU, 32'd9, 32'd3);
    endtask

    task automatic test_back_to_back;
        int          lat;
        logic [31:0] res;
        logic        busy1;
        issue(REMU, 32'd10, 32'd4, lat, res, busy1);
        compare_op("b2b_remu_10_4", REMU, 32'd10, 32'd4, lat, res, busy1);
        // div_valid stays high: the DONE->IDLE cycle follows, then the next accept.
        @(negedge clk);
        vectors++;
        if (div_ready !== 1'b0 || div_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b gap: ready=%b busy=%b expected 0/0", div_ready, div_busy);
        end
        issue(DIVU, 32'hFFFF_FFFF, 32'd1, lat, res, busy1);
        compare_op("b2b_divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, lat, res, busy1);
        div_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort;
        bit seen = 0;
        div_op    = DIVU;
        dividend  = $urandom;
        divisor   = $urandom | 32'd1;
        div_valid = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        div_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_ready) seen = 1;
        end
        vectors++;
        if (seen || div_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort: ready_seen=%b busy=%b expected 0/0", seen, div_busy);
        end
        vectors++;
        if (div_result !== last_exp) begin
            miscompares++;
            $display("FAIL abort result_held: got %h expected %h", div_result, last_exp);
        end
    endtask

    task automatic test_random;
        div_op_e     op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = div_op_e'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 15);
                4:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            do_op("random", op, a, b);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_by_zero;
        test_reset_mid_op;
        test_overflow;
        test_back_to_back;
        test_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
